// File: rtl/instr_mem_loader_if.sv
// Instruction-field handshake and instruction-memory write bus for instr_mem_loader.
interface instr_mem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  Valid_i;
    logic                  Ready_o;
    logic                  Last_i;
    logic [2:0]            Class_i;
    logic [2:0]            Funct3_i;
    logic [6:0]            Funct7_i;
    logic [4:0]            Rd_i;
    logic [4:0]            Rs1_i;
    logic [4:0]            Rs2_i;
    logic [31:0]           Imm_i;
    logic                  Mem_Write_o;
    logic [ADDR_WIDTH-1:0] Mem_Addr_o;
    logic [31:0]           Mem_Data_o;

    modport slave (
        input  Valid_i, Last_i, Class_i, Funct3_i, Funct7_i, Rd_i, Rs1_i, Rs2_i, Imm_i,
        output Ready_o, Mem_Write_o, Mem_Addr_o, Mem_Data_o
    );

    modport master (
        output Valid_i, Last_i, Class_i, Funct3_i, Funct7_i, Rd_i, Rs1_i, Rs2_i, Imm_i,
        input  Ready_o, Mem_Write_o, Mem_Addr_o, Mem_Data_o
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs decoded RV32I fields into instruction words and writes them to consecutive addresses.
// Optional macro IMM_RANGE_CHECK_EN enables the sticky immediate-range error flag.
module instr_mem_loader #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_i,
    instr_mem_loader_if.slave     bus,
    output logic [ADDR_WIDTH:0]   Count_o,
    output logic                  Done_o,
    output logic                  Error_o
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LUI, CLS_JALR, CLS_B, CLS_LW, CLS_SW, CLS_JAL
    } class_t;

    localparam logic [ADDR_WIDTH:0] COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t              state;
    logic                last_q;
    logic [31:0]         enc_word;
    logic [ADDR_WIDTH:0] count_next;

    always_comb begin
        logic [31:0] imm;
        imm      = bus.Imm_i;
        enc_word = '0;
        case (class_t'(bus.Class_i))
            CLS_R:    enc_word = {bus.Funct7_i, bus.Rs2_i, bus.Rs1_i, bus.Funct3_i, bus.Rd_i, 7'h33};
            CLS_I:    enc_word = {imm[11:0], bus.Rs1_i, bus.Funct3_i, bus.Rd_i, 7'h13};
            CLS_LUI:  enc_word = {imm[31:12], bus.Rd_i, 7'h37};
            CLS_JALR: enc_word = {imm[11:0], bus.Rs1_i, 3'b000, bus.Rd_i, 7'h67};
            CLS_B:    enc_word = {imm[12], imm[10:5], bus.Rs2_i, bus.Rs1_i, bus.Funct3_i,
                                  imm[4:1], imm[11], 7'h63};
            CLS_LW:   enc_word = {imm[11:0], bus.Rs1_i, 3'b010, bus.Rd_i, 7'h03};
            CLS_SW:   enc_word = {imm[11:5], bus.Rs2_i, bus.Rs1_i, 3'b010, imm[4:0], 7'h23};
            CLS_JAL:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.Rd_i, 7'h6F};
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic imm_bad;

    // A signed field fits when every bit above its sign bit equals the sign bit.
    always_comb begin
        logic [31:0] imm;
        imm     = bus.Imm_i;
        imm_bad = 1'b0;
        case (class_t'(bus.Class_i))
            CLS_R:                        imm_bad = 1'b0;
            CLS_I, CLS_JALR, CLS_LW, CLS_SW: imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
            CLS_B:   imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            CLS_JAL: imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            CLS_LUI: imm_bad = |imm[11:0];
        endcase
    end
`else
    assign Error_o = 1'b0;
`endif

    assign count_next = (Count_o == COUNT_FULL) ? Count_o : Count_o + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            last_q          <= 1'b0;
            bus.Ready_o     <= 1'b0;
            bus.Mem_Write_o <= 1'b0;
            bus.Mem_Addr_o  <= BASE_ADDR;
            bus.Mem_Data_o  <= '0;
            Count_o         <= '0;
            Done_o          <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
            Error_o         <= 1'b0;
`endif
        end else begin
            bus.Mem_Write_o <= 1'b0;
            // Start wins in every state; a WRITE in flight has already driven its strobe.
            if (Start_i) begin
                state          <= LOAD;
                bus.Ready_o    <= 1'b1;
                bus.Mem_Addr_o <= BASE_ADDR;
                Count_o        <= '0;
                Done_o         <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
                Error_o        <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: ;
                    LOAD: begin
                        if (bus.Valid_i && bus.Ready_o) begin
                            bus.Mem_Data_o  <= enc_word;
                            last_q          <= bus.Last_i;
                            bus.Mem_Write_o <= 1'b1;
                            bus.Ready_o     <= 1'b0;
                            state           <= WRITE;
`ifdef IMM_RANGE_CHECK_EN
                            Error_o         <= Error_o | imm_bad;
`endif
                        end
                    end
                    WRITE: begin
                        bus.Mem_Addr_o <= bus.Mem_Addr_o + 1'b1;
                        Count_o        <= count_next;
                        if (last_q || count_next == COUNT_FULL) begin
                            state  <= DONE;
                            Done_o <= 1'b1;
                        end else begin
                            state       <= LOAD;
                            bus.Ready_o <= 1'b1;
                        end
                    end
                    DONE: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader: encoding table, stream timing, restart and full-memory cases.
module tb_instr_mem_loader;
    logic       clk;
    logic       reset;
    logic       start_a;
    logic       start_b;
    logic [8:0] count_a;
    logic [2:0] count_b;
    logic       done_a, done_b;
    logic       err_a, err_b;
    int         checks;
    int         failures;
    int         cyc;

    instr_mem_loader_if #(.ADDR_WIDTH(8)) ifa ();
    instr_mem_loader_if #(.ADDR_WIDTH(2)) ifb ();

    instr_mem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(8'd0)) dut_a (
        .clk(clk), .reset(reset), .Start_i(start_a), .bus(ifa),
        .Count_o(count_a), .Done_o(done_a), .Error_o(err_a)
    );

    instr_mem_loader #(.ADDR_WIDTH(2), .BASE_ADDR(2'd0)) dut_b (
        .clk(clk), .reset(reset), .Start_i(start_b), .bus(ifb),
        .Count_o(count_b), .Done_o(done_b), .Error_o(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  cls;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        last;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        int n = 0;
        while (!ifa.Ready_o && n < 20) begin
            tick();
            n++;
        end
        if (!ifa.Ready_o) check("ready_a_timeout", 32'(ifa.Ready_o), 32'd1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Drives one instruction on instance A and leaves time just after its accepting edge.
    task automatic send_a(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic last);
        wait_ready_a();
        ifa.Class_i  = cls;
        ifa.Funct3_i = f3;
        ifa.Funct7_i = f7;
        ifa.Rd_i     = rd;
        ifa.Rs1_i    = rs1;
        ifa.Rs2_i    = rs2;
        ifa.Imm_i    = imm;
        ifa.Last_i   = last;
        ifa.Valid_i  = 1'b1;
        tick();
        ifa.Valid_i  = 1'b0;
    endtask

    initial begin
        logic exp_err;
        int   prev_cyc;
        int   n;
        logic saw_write;

`ifdef IMM_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        checks   = 0;
        failures = 0;

        vecs[0] = '{3'd0, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h002081B3};
        vecs[1] = '{3'd6, 3'd0, 7'h00, 5'd5, 5'd1, 5'd2, 32'd8,          1'b0, 32'h0020A423};
        vecs[2] = '{3'd7, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,          1'b0, 32'h008000EF};
        vecs[3] = '{3'd4, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   1'b0, 32'hFE208EE3};
        vecs[4] = '{3'd2, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,   1'b0, 32'h123452B7};
        vecs[5] = '{3'd3, 3'd3, 7'h00, 5'd1, 5'd5, 5'd7, 32'd4,          1'b0, 32'h004280E7};
        vecs[6] = '{3'd5, 3'd7, 7'h00, 5'd2, 5'd3, 5'd0, 32'd12,         1'b0, 32'h00C1A103};
        vecs[7] = '{3'd0, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0,          1'b0, 32'h403100B3};
        vecs[8] = '{3'd7, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFF8,   1'b1, 32'hFF9FF06F};

        reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ifa.Valid_i = 1'b0; ifa.Last_i = 1'b0; ifa.Class_i = '0; ifa.Funct3_i = '0;
        ifa.Funct7_i = '0; ifa.Rd_i = '0; ifa.Rs1_i = '0; ifa.Rs2_i = '0; ifa.Imm_i = '0;
        ifb.Valid_i = 1'b0; ifb.Last_i = 1'b0; ifb.Class_i = '0; ifb.Funct3_i = '0;
        ifb.Funct7_i = '0; ifb.Rd_i = '0; ifb.Rs1_i = '0; ifb.Rs2_i = '0; ifb.Imm_i = '0;

        tick();
        tick();
        check("rst_ready", 32'(ifa.Ready_o), 32'd0);
        check("rst_write", 32'(ifa.Mem_Write_o), 32'd0);
        check("rst_addr", 32'(ifa.Mem_Addr_o), 32'd0);
        check("rst_data", ifa.Mem_Data_o, 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_error", 32'(err_a), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_ready", 32'(ifa.Ready_o), 32'd0);

        // Single I-logic instruction with Last set.
        pulse_start_a();
        check("start_ready", 32'(ifa.Ready_o), 32'd1);
        send_a(3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        check("single_write", 32'(ifa.Mem_Write_o), 32'd1);
        check("single_data", ifa.Mem_Data_o, 32'h00500093);
        check("single_addr", 32'(ifa.Mem_Addr_o), 32'd0);
        check("single_ready_low", 32'(ifa.Ready_o), 32'd0);
        check("single_err", 32'(err_a), 32'd0);
        tick();
        check("single_done", 32'(done_a), 32'd1);
        check("single_count", 32'(count_a), 32'd1);
        check("single_strobe_len", 32'(ifa.Mem_Write_o), 32'd0);
        check("single_done_ready", 32'(ifa.Ready_o), 32'd0);

        // Back-to-back table stream with Valid held high.
        pulse_start_a();
        prev_cyc = 0;
        ifa.Valid_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wait_ready_a();
            ifa.Class_i  = vecs[i].cls;
            ifa.Funct3_i = vecs[i].f3;
            ifa.Funct7_i = vecs[i].f7;
            ifa.Rd_i     = vecs[i].rd;
            ifa.Rs1_i    = vecs[i].rs1;
            ifa.Rs2_i    = vecs[i].rs2;
            ifa.Imm_i    = vecs[i].imm;
            ifa.Last_i   = vecs[i].last;
            tick();
            check($sformatf("vec%0d_write", i), 32'(ifa.Mem_Write_o), 32'd1);
            check($sformatf("vec%0d_data", i), ifa.Mem_Data_o, vecs[i].exp_word);
            check($sformatf("vec%0d_addr", i), 32'(ifa.Mem_Addr_o), 32'(i));
            check($sformatf("vec%0d_count", i), 32'(count_a), 32'(i));
            if (i > 0) check($sformatf("vec%0d_spacing", i), 32'(cyc - prev_cyc), 32'd2);
            prev_cyc = cyc;
        end
        ifa.Valid_i = 1'b0;
        ifa.Last_i  = 1'b0;
        tick();
        check("stream_done", 32'(done_a), 32'd1);
        check("stream_count", 32'(count_a), 32'd9);
        check("stream_err", 32'(err_a), 32'd0);

        // Restart requested while the word at address 2 is being written.
        pulse_start_a();
        send_a(3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        send_a(3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2, 1'b0);
        send_a(3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
        check("rs_write_addr2", 32'(ifa.Mem_Addr_o), 32'd2);
        check("rs_write_strobe", 32'(ifa.Mem_Write_o), 32'd1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("rs_strobe_ended", 32'(ifa.Mem_Write_o), 32'd0);
        check("rs_ready", 32'(ifa.Ready_o), 32'd1);
        check("rs_count", 32'(count_a), 32'd0);
        check("rs_addr", 32'(ifa.Mem_Addr_o), 32'd0);
        send_a(3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        check("rs_next_addr", 32'(ifa.Mem_Addr_o), 32'd0);
        check("rs_next_data", ifa.Mem_Data_o, 32'h00500093);
        tick();
        check("rs_done", 32'(done_a), 32'd1);

        // Out-of-range I-type immediate: word truncated, error flag depends on build.
        pulse_start_a();
        send_a(3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
        check("range_data", ifa.Mem_Data_o, 32'h80000093);
        check("range_err", 32'(err_a), 32'(exp_err));
        tick();
        check("range_err_sticky", 32'(err_a), 32'(exp_err));
        pulse_start_a();
        check("range_err_cleared", 32'(err_a), 32'd0);

        // Reset asserted during a write strobe.
        send_a(3'd1, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0);
        check("rm_strobe_before", 32'(ifa.Mem_Write_o), 32'd1);
        reset = 1'b0;
        #1;
        check("rm_strobe_dropped", 32'(ifa.Mem_Write_o), 32'd0);
        check("rm_count", 32'(count_a), 32'd0);
        #2;
        reset = 1'b1;
        tick();
        check("rm_idle_ready", 32'(ifa.Ready_o), 32'd0);

        // ADDR_WIDTH=2: four writes fill memory, fifth instruction refused.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        ifb.Class_i = 3'd1;
        ifb.Rd_i    = 5'd1;
        ifb.Valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [11:0] kimm;
            n = 0;
            while (!ifb.Ready_o && n < 20) begin
                tick();
                n++;
            end
            if (!ifb.Ready_o) check("ready_b_timeout", 32'(ifb.Ready_o), 32'd1);
            kimm = 12'(k + 1);
            ifb.Imm_i = 32'(kimm);
            tick();
            check($sformatf("full_write%0d", k), 32'(ifb.Mem_Write_o), 32'd1);
            check($sformatf("full_addr%0d", k), 32'(ifb.Mem_Addr_o), 32'(k));
            check($sformatf("full_data%0d", k), ifb.Mem_Data_o, {kimm, 20'h00093});
        end
        tick();
        check("full_done", 32'(done_b), 32'd1);
        check("full_count", 32'(count_b), 32'd4);
        check("full_ready", 32'(ifb.Ready_o), 32'd0);
        check("full_addr_wrap", 32'(ifb.Mem_Addr_o), 32'd0);
        saw_write = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (ifb.Mem_Write_o || ifb.Ready_o) saw_write = 1'b1;
        end
        check("full_fifth_refused", 32'(saw_write), 32'd0);
        check("full_count_sat", 32'(count_b), 32'd4);
        ifb.Valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
